// File: rtl/mac_seq_accumulator_pkg.sv
// Shared definitions for the MAC accumulator and its 4x4 multiplier:
// FSM state encoding and operand width.
package mac_seq_accumulator_pkg;

    localparam int OP_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mac_seq_accumulator_mult.sv
// Unsigned OP_W x OP_W combinational array multiplier: one shifted partial
// product per multiplier bit, summed into a 2*OP_W-bit product.
module mac_seq_accumulator_mult
    import mac_seq_accumulator_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [2*OP_W-1:0] p
);

    logic [2*OP_W-1:0] pp [OP_W];

    generate
        for (genvar gi = 0; gi < OP_W; gi++) begin : g_pp
            assign pp[gi] = b[gi] ? ((2*OP_W)'(a) << gi) : '0;
        end
    endgenerate

    always_comb begin
        p = '0;
        for (int i = 0; i < OP_W; i++) begin
            p = p + pp[i];
        end
    end

endmodule

// File: rtl/mac_seq_accumulator.sv
// Sequential multiply-accumulate: registers a host-defined run of operand
// pairs into the array multiplier and sums the products into a wide result.
module mac_seq_accumulator
    import mac_seq_accumulator_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] sum,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    state_t             state_reg, state_next;
    logic [OP_W-1:0]    a_reg, b_reg;
    logic               v_reg;
    logic [LEN_W-1:0]   cnt_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic               ovf_reg;
    logic [2*OP_W-1:0]  prod;
    logic [ACC_W:0]     acc_next;
    logic               transfer;

    mac_seq_accumulator_mult u_mult (
        .a (a_reg),
        .b (b_reg),
        .p (prod)
    );

    // Extra top bit of acc_next is the carry out of the accumulator.
    assign acc_next = {1'b0, acc_reg} + {{(ACC_W+1-2*OP_W){1'b0}}, prod};
    assign transfer = in_ready & in_valid;
    assign sum      = acc_reg;
    assign ovf      = ovf_reg;

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = (state_reg != IDLE);
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                if (in_valid && cnt_reg == LEN_W'(1)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            v_reg     <= 1'b0;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            v_reg     <= transfer;
            if (transfer) begin
                a_reg   <= a;
                b_reg   <= b;
                cnt_reg <= cnt_reg - LEN_W'(1);
            end
            // v_reg is never set in IDLE, so the start clear cannot race an add.
            if (state_reg == IDLE && start) begin
                acc_reg <= '0;
                ovf_reg <= 1'b0;
                if (len != '0) begin
                    cnt_reg <= len;
                end
            end else if (v_reg) begin
                acc_reg <= acc_next[ACC_W-1:0];
                if (acc_next[ACC_W]) begin
                    ovf_reg <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_seq_accumulator.sv
// Scoreboard bench: a default-width and a 10-bit instance share stimulus;
// expected results are queued at run start and checked at out_valid.
module tb_mac_seq_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] len = '0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;

    logic        in_ready_16, out_valid_16, ovf_16, busy_16;
    logic [15:0] sum_16;
    logic        in_ready_10, out_valid_10, ovf_10, busy_10;
    logic [9:0]  sum_10;

    typedef struct {
        int sum16;
        int sum10;
        bit ovf16;
        bit ovf10;
    } exp_t;

    exp_t sb[$];
    int   pa[$];
    int   pb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mac_seq_accumulator #(.ACC_W(16), .LEN_W(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .a(a), .b(b),
        .in_valid(in_valid), .in_ready(in_ready_16), .sum(sum_16), .ovf(ovf_16),
        .out_valid(out_valid_16), .out_ready(out_ready), .busy(busy_16)
    );

    mac_seq_accumulator #(.ACC_W(10), .LEN_W(4)) dut10 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .a(a), .b(b),
        .in_valid(in_valid), .in_ready(in_ready_10), .sum(sum_10), .ovf(ovf_10),
        .out_valid(out_valid_10), .out_ready(out_ready), .busy(busy_10)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic load_pairs(input int n, input int av[16], input int bv[16]);
        pa.delete();
        pb.delete();
        for (int i = 0; i < n; i++) begin
            pa.push_back(av[i]);
            pb.push_back(bv[i]);
        end
    endtask

    // Issue start with the current pair list; optionally queue the expected result.
    task automatic begin_run(input int n, input bit push);
        exp_t e;
        int   total = 0;
        for (int i = 0; i < n; i++) total += pa[i] * pb[i];
        e.sum16 = total % 65536;
        e.sum10 = total % 1024;
        e.ovf16 = (total >= 65536);
        e.ovf10 = (total >= 1024);
        if (push) sb.push_back(e);
        start = 1'b1;
        len   = 4'(n);
        step();
        start = 1'b0;
        len   = '0;
    endtask

    task automatic send_pairs(input int n, input int gap, output int xfers);
        int w;
        xfers = 0;
        for (int i = 0; i < n; i++) begin
            a = 4'(pa[i]);
            b = 4'(pb[i]);
            in_valid = 1'b1;
            w = 0;
            while (!in_ready_16 && w < 20) begin
                step();
                w++;
            end
            if (w == 20) begin
                n_cmp++;
                n_err++;
                $display("FAIL send_timeout pair %0d: in_ready never rose", i);
            end
            step();
            xfers++;
            if (gap > 0) begin
                in_valid = 1'b0;
                for (int g = 0; g < gap; g++) begin
                    a = 4'($urandom_range(15));
                    b = 4'($urandom_range(15));
                    step();
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic get_result(input string name, input int stall);
        exp_t e;
        int   w = 0;
        logic [15:0] held;
        out_ready = 1'b0;
        while (!out_valid_16 && w < 50) begin
            step();
            w++;
        end
        n_cmp++;
        if (!out_valid_16 || !out_valid_10) begin
            n_err++;
            $display("FAIL %s out_valid: got %b/%b, want 1/1", name, out_valid_16, out_valid_10);
        end
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s scoreboard: result with no expected entry", name);
            return;
        end
        e = sb.pop_front();
        n_cmp++;
        if (sum_16 !== 16'(e.sum16) || ovf_16 !== e.ovf16) begin
            n_err++;
            $display("FAIL %s sum16: got %0d ovf %b, want %0d ovf %b", name, sum_16, ovf_16, e.sum16, e.ovf16);
        end
        n_cmp++;
        if (sum_10 !== 10'(e.sum10) || ovf_10 !== e.ovf10) begin
            n_err++;
            $display("FAIL %s sum10: got %0d ovf %b, want %0d ovf %b", name, sum_10, ovf_10, e.sum10, e.ovf10);
        end
        held = 16'(e.sum16);
        for (int s = 0; s < stall; s++) begin
            step();
            n_cmp++;
            if (out_valid_16 !== 1'b1 || sum_16 !== held) begin
                n_err++;
                $display("FAIL %s stall%0d: out_valid %b sum %0d, want 1 sum %0d", name, s, out_valid_16, sum_16, held);
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid_16 !== 1'b0 || busy_16 !== 1'b0 || sum_16 !== held) begin
            n_err++;
            $display("FAIL %s release: out_valid %b busy %b sum %0d, want 0 0 %0d", name, out_valid_16, busy_16, sum_16, held);
        end
        $display("run %s: sum16=%0d sum10=%0d ovf10=%b", name, e.sum16, e.sum10, e.ovf10);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        n_cmp++;
        if ({in_ready_16, out_valid_16, busy_16, ovf_16, in_ready_10, out_valid_10, busy_10, ovf_10} !== 8'h00
            || sum_16 !== 16'd0 || sum_10 !== 10'd0) begin
            n_err++;
            $display("FAIL reset: rdy %b vld %b busy %b ovf %b sum %0d, want all 0",
                     in_ready_16, out_valid_16, busy_16, ovf_16, sum_16);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic;
        int av[16] = '{default: 15};
        int bv[16] = '{default: 15};
        int x;
        load_pairs(3, av, bv);
        begin_run(3, 1'b1);
        send_pairs(3, 0, x);
        n_cmp++;
        if (in_ready_16 !== 1'b0 || out_valid_16 !== 1'b0 || busy_16 !== 1'b1) begin
            n_err++;
            $display("FAIL basic_drain: rdy %b vld %b busy %b, want 0 0 1", in_ready_16, out_valid_16, busy_16);
        end
        step();
        n_cmp++;
        if (out_valid_16 !== 1'b1) begin
            n_err++;
            $display("FAIL basic_latency: out_valid %b, want 1", out_valid_16);
        end
        get_result("basic", 0);
    endtask

    task automatic test_backpressure;
        int av[16] = '{0: 3, 1: 0, 2: 7, 3: 1, default: 0};
        int bv[16] = '{0: 5, 1: 9, 2: 2, 3: 1, default: 0};
        int x;
        load_pairs(4, av, bv);
        begin_run(4, 1'b1);
        send_pairs(4, 2, x);
        get_result("backpressure", 0);
    endtask

    task automatic test_overflow;
        int av[16] = '{default: 15};
        int bv[16] = '{default: 15};
        int cv[16] = '{0: 2, default: 0};
        int dv[16] = '{0: 3, default: 0};
        int x;
        load_pairs(5, av, bv);
        begin_run(5, 1'b1);
        send_pairs(5, 0, x);
        get_result("overflow", 0);
        load_pairs(1, cv, dv);
        begin_run(1, 1'b1);
        send_pairs(1, 0, x);
        get_result("after_overflow", 0);
    endtask

    task automatic test_zero_len_stall;
        pa.delete();
        pb.delete();
        begin_run(0, 1'b1);
        n_cmp++;
        if (out_valid_16 !== 1'b1 || busy_16 !== 1'b1) begin
            n_err++;
            $display("FAIL zero_len_done: out_valid %b busy %b, want 1 1", out_valid_16, busy_16);
        end
        get_result("zero_len", 5);
    endtask

    task automatic test_ignored;
        int av[16] = '{0: 4, 1: 2, default: 0};
        int bv[16] = '{0: 4, 1: 8, default: 0};
        a = 4'd9;
        b = 4'd9;
        in_valid = 1'b1;
        repeat (3) step();
        in_valid = 1'b0;
        n_cmp++;
        if (busy_16 !== 1'b0 || in_ready_16 !== 1'b0) begin
            n_err++;
            $display("FAIL idle_in_valid: busy %b in_ready %b, want 0 0", busy_16, in_ready_16);
        end
        load_pairs(2, av, bv);
        begin_run(2, 1'b1);
        a = 4'd4;
        b = 4'd4;
        in_valid = 1'b1;
        step();
        start = 1'b1;
        len = 4'd9;
        a = 4'd2;
        b = 4'd8;
        step();
        start = 1'b0;
        len = '0;
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready_16 !== 1'b0 || busy_16 !== 1'b1) begin
            n_err++;
            $display("FAIL run_start_ignored: in_ready %b busy %b, want 0 1", in_ready_16, busy_16);
        end
        get_result("ignored", 0);
    endtask

    task automatic test_reset_mid;
        int av[16] = '{default: 5};
        int bv[16] = '{default: 7};
        int cv[16] = '{0: 6, default: 0};
        int dv[16] = '{0: 7, default: 0};
        int x;
        load_pairs(6, av, bv);
        begin_run(6, 1'b0);
        send_pairs(3, 0, x);
        in_valid = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready_16, out_valid_16, busy_16, ovf_16} !== 4'b0000 || sum_16 !== 16'd0 || sum_10 !== 10'd0) begin
            n_err++;
            $display("FAIL reset_mid: rdy %b vld %b busy %b ovf %b sum %0d, want all 0",
                     in_ready_16, out_valid_16, busy_16, ovf_16, sum_16);
        end
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        load_pairs(1, cv, dv);
        begin_run(1, 1'b1);
        send_pairs(1, 0, x);
        get_result("after_reset", 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_zero_len_stall();
        test_ignored();
        test_reset_mid();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d results outstanding, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
